// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the execute stage and the HI/LO multiply/divide unit.
// Handshake: an issue is taken on the rising edge where i_start=1, i_flush=0 and o_ready=1;
// otherwise the issuer holds i_start/i_op/i_a/i_b stable until o_ready is seen.
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_start;
  logic [2:0]            i_op;
  logic [DATA_WIDTH-1:0] i_a;
  logic [DATA_WIDTH-1:0] i_b;
  logic                  i_flush;
  logic                  o_ready;
  logic                  o_busy;
  logic                  o_done;
  logic [DATA_WIDTH-1:0] o_hi;
  logic [DATA_WIDTH-1:0] o_lo;
  logic [1:0]            o_dbg_state;

  modport master (
    output i_start, i_op, i_a, i_b, i_flush,
    input  o_ready, o_busy, o_done, o_hi, o_lo, o_dbg_state
  );

  modport slave (
    input  i_start, i_op, i_a, i_b, i_flush,
    output o_ready, o_busy, o_done, o_hi, o_lo, o_dbg_state
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU unit that owns the HI/LO pair.
// Signed operations run on magnitudes; signs are re-applied in the FIX cycle.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state, w_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [W-1:0]         r_hi, r_lo;
  logic [W-1:0]         r_mcand;
  logic [2*W-1:0]       r_acc;
  logic [W-1:0]         r_quo, r_rem;
  logic [W-1:0]         r_orig_a;
  logic                 r_is_div, r_sq, r_sr, r_div0, r_done;

  logic                 w_issue, w_signed, w_sa, w_sb;
  logic [W-1:0]         w_mag_a, w_mag_b;
  logic [W:0]           w_msum, w_dshift, w_ddiff;
  logic [2*W-1:0]       w_prod_fix;

  assign w_issue  = (r_state == S_IDLE) && bus.i_start && !bus.i_flush;
  assign w_signed = !bus.i_op[2] && !bus.i_op[0];
  assign w_sa     = w_signed & bus.i_a[W-1];
  assign w_sb     = w_signed & bus.i_b[W-1];
  assign w_mag_a  = w_sa ? -bus.i_a : bus.i_a;
  assign w_mag_b  = w_sb ? -bus.i_b : bus.i_b;

  // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign w_msum   = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  // Divide: restoring step; a clear bit W of the difference means the divisor fits.
  assign w_dshift = {r_rem, r_quo[W-1]};
  assign w_ddiff  = w_dshift - {1'b0, r_mcand};
  assign w_prod_fix = r_sq ? -r_acc : r_acc;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_issue && !bus.i_op[2]) w_next = S_RUN;
      S_RUN: begin
        if (bus.i_flush)                   w_next = S_IDLE;
        else if (r_cnt == CNT_WIDTH'(1))   w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_orig_a <= '0;
      r_is_div <= 1'b0;
      r_sq     <= 1'b0;
      r_sr     <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            case (bus.i_op)
              3'd4: r_hi <= bus.i_a;
              3'd5: r_lo <= bus.i_a;
              3'd0, 3'd1, 3'd2, 3'd3: begin
                r_is_div <= bus.i_op[1];
                r_sq     <= w_sa ^ w_sb;
                r_sr     <= w_sa;
                r_div0   <= (bus.i_b == '0);
                r_orig_a <= bus.i_a;
                r_mcand  <= bus.i_op[1] ? w_mag_b : w_mag_a;
                r_acc    <= {{W{1'b0}}, w_mag_b};
                r_quo    <= w_mag_a;
                r_rem    <= '0;
                r_cnt    <= CNT_WIDTH'(W);
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (!bus.i_flush) begin
            r_cnt <= r_cnt - 1'b1;
            if (!r_is_div) begin
              r_acc <= {w_msum, r_acc[W-1:1]};
            end else if (!w_ddiff[W]) begin
              r_rem <= w_ddiff[W-1:0];
              r_quo <= {r_quo[W-2:0], 1'b1};
            end else begin
              r_rem <= w_dshift[W-1:0];
              r_quo <= {r_quo[W-2:0], 1'b0};
            end
          end
        end
        S_FIX: begin
          if (!bus.i_flush) begin
            r_done <= 1'b1;
            if (!r_is_div) begin
              r_hi <= w_prod_fix[2*W-1:W];
              r_lo <= w_prod_fix[W-1:0];
            end else if (r_div0) begin
              r_hi <= r_orig_a;
              r_lo <= '1;
            end else begin
              r_hi <= r_sr ? -r_rem : r_rem;
              r_lo <= r_sq ? -r_quo : r_quo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_ready     = (r_state == S_IDLE);
  assign bus.o_done      = r_done;
  assign bus.o_hi        = r_hi;
  assign bus.o_lo        = r_lo;
  assign bus.o_dbg_state = r_state;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases, then random ops checked against
// a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk;
  logic rst;
  muldiv_unit_if #(.DATA_WIDTH(W)) bus();

  muldiv_unit #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi, m_lo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference HI/LO result, written straight from the arithmetic definitions.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb, q, r;
    logic [63:0] p, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      3'd0: begin p = 64'(sa * sb); return p; end
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      3'd4: return {a, cur[31:0]};
      3'd5: return {cur[63:32], a};
      default: return cur;
    endcase
  endfunction

  // Driver tasks start and end just after a falling edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int lat;
    int busy_n;
    bit seen;
    logic [63:0] e;
    exp_q.push_back(exp);
    bus.i_start = 1'b1;
    bus.i_op = op;
    bus.i_a = a;
    bus.i_b = b;
    @(negedge clk);
    bus.i_start = 1'b0;
    lat = 0;
    busy_n = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      if (bus.o_busy) busy_n++;
      if (lat == 5) begin
        check("hold_hi", bus.o_hi, m_hi);
        check("hold_lo", bus.o_lo, m_lo);
      end
      if (bus.o_done) seen = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    e = exp_q.pop_front();
    check("done_seen", seen, 1);
    check("latency", lat, 33);
    check("busy_cycles", busy_n, 33);
    check("ready_at_done", bus.o_ready, 1);
    check("hi", bus.o_hi, e[63:32]);
    check("lo", bus.o_lo, e[31:0]);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    logic [63:0] e;
    exp_q.push_back(model(op, a, 32'h0, {m_hi, m_lo}));
    bus.i_start = 1'b1;
    bus.i_op = op;
    bus.i_a = a;
    bus.i_b = $urandom;
    @(negedge clk);
    bus.i_start = 1'b0;
    e = exp_q.pop_front();
    check("mt_done", bus.o_done, 0);
    check("mt_busy", bus.o_busy, 0);
    check("mt_hi", bus.o_hi, e[63:32]);
    check("mt_lo", bus.o_lo, e[31:0]);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  initial begin
    bit any_done;
    logic [2:0] op;
    logic [31:0] a, b;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_op = 3'd0;
    bus.i_a = '0;
    bus.i_b = '0;
    bus.i_flush = 1'b0;
    m_hi = '0;
    m_lo = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_hi", bus.o_hi, 0);
    check("rst_lo", bus.o_lo, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_ready", bus.o_ready, 1);
    check("rst_state", bus.o_dbg_state, 0);

    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001});
    run_op(3'd0, 32'hFFFFFFFD, 32'd5,        {32'hFFFFFFFF, 32'hFFFFFFF1});
    run_op(3'd2, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000});
    run_op(3'd3, 32'd7,        32'd0,        {32'h00000007, 32'hFFFFFFFF});
    run_op(3'd2, 32'hFFFFFFF9, 32'd0,        {32'hFFFFFFF9, 32'hFFFFFFFF});

    // Preset HI/LO, then flush a DIVU at E10.
    mt(3'd4, 32'h11);
    mt(3'd5, 32'h22);
    bus.i_start = 1'b1;
    bus.i_op = 3'd3;
    bus.i_a = 32'd100;
    bus.i_b = 32'd3;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_pre_busy", bus.o_busy, 1);
    bus.i_flush = 1'b1;
    bus.i_start = 1'b1;
    bus.i_op = 3'd4;
    bus.i_a = 32'hBAD0;
    @(negedge clk);
    bus.i_flush = 1'b0;
    bus.i_start = 1'b0;
    check("flush_busy", bus.o_busy, 0);
    check("flush_hi", bus.o_hi, 32'h11);
    check("flush_lo", bus.o_lo, 32'h22);
    any_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_done) any_done = 1;
      @(negedge clk);
    end
    check("flush_no_done", any_done, 0);
    check("flush_hi_late", bus.o_hi, 32'h11);

    // MTHI offered for one cycle while busy must be dropped.
    exp_q.push_back(model(3'd1, 32'd3, 32'd4, {m_hi, m_lo}));
    bus.i_start = 1'b1;
    bus.i_op = 3'd1;
    bus.i_a = 32'd3;
    bus.i_b = 32'd4;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (4) @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op = 3'd4;
    bus.i_a = 32'hDEAD;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("busy_mthi_hi", bus.o_hi, 32'h11);
    for (int i = 0; i < 60 && !bus.o_done; i++) @(negedge clk);
    check("busy_done", bus.o_done, 1);
    begin
      logic [63:0] e;
      e = exp_q.pop_front();
      check("busy_mthi_res_hi", bus.o_hi, e[63:32]);
      check("busy_mthi_res_lo", bus.o_lo, e[31:0]);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
    @(negedge clk);
    check("busy_mthi_late", bus.o_hi, m_hi);

    // Reset at E15 of a MULT.
    bus.i_start = 1'b1;
    bus.i_op = 3'd0;
    bus.i_a = 32'd6;
    bus.i_b = 32'd7;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_hi", bus.o_hi, 0);
    check("midrst_lo", bus.o_lo, 0);
    check("midrst_busy", bus.o_busy, 0);
    m_hi = '0;
    m_lo = '0;
    repeat (40) @(negedge clk);
    check("midrst_no_result", bus.o_lo, 0);

    // start together with flush in IDLE is not an issue.
    bus.i_start = 1'b1;
    bus.i_flush = 1'b1;
    bus.i_op = 3'd0;
    bus.i_a = 32'd3;
    bus.i_b = 32'd4;
    @(negedge clk);
    check("sf_mult_busy", bus.o_busy, 0);
    bus.i_op = 3'd4;
    bus.i_a = 32'h55;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
    check("sf_mthi_hi", bus.o_hi, 0);

    // Random mix; run_op returns in the done cycle, so the next issue is back-to-back.
    for (int k = 0; k < 30; k++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      case ($urandom_range(0, 4))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if (op <= 3'd3) run_op(op, a, b, model(op, a, b, {m_hi, m_lo}));
      else mt(op, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
